step_counter_display: RTL and testbench
=======================================

Name: step_counter_display

Overview:
- Parametrised successor to the fixed +10/0..150 auto-counter driving three seven-segment digits.
- Counts by a run-time step, up or down, bounded by a run-time limit, with four boundary modes.
- The prescaler is a clock-enable tick, not a derived clock.
- A multi-cycle sequential binary-to-BCD converter feeds DIGITS seven-segment outputs.
- Sits between board clock/reset and the display pins.

Parameters:
- WIDTH, 8: counter, step, limit and load widths. Must satisfy 2^WIDTH-1 <= 10^DIGITS-1; elaboration error otherwise.
- DIGITS, 3: number of decimal digits / seven-segment outputs.
- DIV, 33554432: prescaler period in clk cycles (>=1).
- RST_LIMIT, 150: documentation/reset-default limit value for integrators. Hardware uses the limit port.

Ports:
- clk  in  1  single system clock; all flops posedge clk.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); deassertion synchronised externally.
- en  in  1  run enable; prescaler and counter hold when 0.
- up  in  1  direction, 1 = up.
- mode  in  2  boundary mode: 0 WRAP, 1 SAT, 2 BOUNCE, 3 ONESHOT.
- step  in  WIDTH  increment per tick.
- limit  in  WIDTH  upper bound (inclusive).
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value for load.
- tick  out  1  one-cycle prescaler pulse.
- count  out  WIDTH  current count.
- boundary  out  1  one-cycle pulse on a boundary event.
- busy  out  1  BCD conversion in progress.
- bcd  out  4*DIGITS  packed BCD of last converted count, digit 0 = units.
- seg  out  7*DIGITS  active-low segments {g..a} per digit, digit 0 = units.

Behaviour:
- Reset (reset=0):
  - Prescaler counter = 0; tick = 0; count = 0; dir = up (1); done = 0; boundary = 0; busy = 0.
  - bcd = 0; every seg digit = 7'b1000000 ("0").
- Prescaler:
  - div_cnt counts 0..DIV-1 while en=1 and holds while en=0.
  - tick = 1 for exactly one cycle when div_cnt == DIV-1 and en=1; div_cnt then wraps to 0.
  - DIV=1: tick = en every cycle.
- Priority, per cycle: load > tick > hold.
- Load:
  - count <= min(load_value, limit); div_cnt <= 0; dir <= up; done <= 0.
  - No boundary pulse.
- Effective direction: d = dir in BOUNCE; d = up in all other modes.
- On tick, done=0, d=up:
  - count < limit: count <= min(count+step, limit), computed at WIDTH+1 bits, no overflow.
  - count >= limit: boundary event.
- On tick, done=0, d=down:
  - count > 0: count <= (count>=step) ? count-step : 0.
  - count == 0: boundary event.
- Boundary event: boundary=1 for that cycle, then:
  - WRAP: up → 0; down → limit.
  - SAT: count holds.
  - BOUNCE: dir <= ~dir. Up boundary → count <= limit-min(step,limit). Down boundary → count <= min(step,limit).
  - ONESHOT: count holds; done <= 1. Further ticks are ignored (tick still pulses) until load.
- step=0: count never moves; boundary fires only when already at the bound.
- Limit lowered below count: the next up-tick is a boundary event. WRAP gives 0; SAT/ONESHOT hold the stale count until load.
- BCD converter (shift-add-3):
  - Starts the cycle after any count change, and once after reset release.
  - Takes WIDTH cycles with busy=1; bcd and seg update together on the completion cycle.
  - Latency: count change → seg valid = WIDTH+1 cycles.
  - Count changes mid-conversion set a pending flag. The conversion finishes, then restarts immediately with the latest count; intermediate values may never display.
  - bcd/seg never show partial results.
- Seg encoding (active-low): 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0010000. No leading-zero blanking.
- Reset assertion mid-conversion or mid-prescale aborts immediately to reset values.

Test Plan:
- DIV=4, step=10, limit=150, mode=WRAP, up=1, en=1 → tick every 4 cycles. count 0,10,…,150, then 0 with boundary=1 on that tick. seg after 150 reads "1","5","0" WIDTH+1 cycles after the update.
- mode=SAT, step=40, limit=150 → 0,40,80,120,150,150; boundary pulses on every tick at 150.
- mode=BOUNCE, step=60, limit=150 → 0,60,120,150,90,30,0,60. Boundary on the 150→90 tick and the 0→60 tick.
- Down WRAP, load 5, step=10, limit=99 → load gives 5; ticks give 0, then 99 (boundary), then 89.
- ONESHOT up, step=100, limit=255 → 100,200,255, then holds; boundary on the 4th tick only. load 7 resumes counting at 7.
- DIV=1 with count changing every cycle → busy stays 1 and seg always shows a complete value. After en=0, seg settles to the final count within 2*(WIDTH+1) cycles. Asserting reset=0 mid-run → all outputs reset asynchronously, seg="000".

Source files
------------

// File: rtl/step_counter_display.sv
// Step/limit/mode counter paced by a clock-enable prescaler, with a sequential
// shift-add-3 binary-to-BCD converter driving active-low seven-segment digits.
module step_counter_display #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned DIV       = 33554432,
    parameter int unsigned RST_LIMIT = 150
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic [1:0]          mode,
    input  logic [WIDTH-1:0]    step,
    input  logic [WIDTH-1:0]    limit,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_value,
    output logic                tick,
    output logic [WIDTH-1:0]    count,
    output logic                boundary,
    output logic                busy,
    output logic [4*DIGITS-1:0] bcd,
    output logic [7*DIGITS-1:0] seg
);

    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;
    localparam longint unsigned MAX_DEC = (64'd10 ** DIGITS) - 64'd1;
    localparam int unsigned     DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned     BW      = $clog2(WIDTH + 1);
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);

    generate
        if (MAX_BIN > MAX_DEC) begin : g_width_check
            $error("WIDTH too large for DIGITS decimal digits");
        end
        if (DIV < 1) begin : g_div_check
            $error("DIV must be at least 1");
        end
        if (RST_LIMIT > MAX_BIN) begin : g_limit_check
            $error("RST_LIMIT does not fit in WIDTH bits");
        end
    endgenerate

    typedef enum logic [1:0] {WRAP = 2'd0, SAT = 2'd1, BOUNCE = 2'd2, ONESHOT = 2'd3} mode_t;
    typedef enum logic {CONV_IDLE, CONV_RUN} conv_t;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    mode_t               m;
    conv_t               conv_st;
    logic [DW-1:0]       div_cnt;
    logic                armed, dir, done, pend;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    step_cl, count_nxt;
    logic                d, dir_nxt, done_nxt, bnd_nxt, chg, last, start;
    logic [WIDTH-1:0]    bin;
    logic [4*DIGITS-1:0] work, adj, shifted;
    logic [7*DIGITS-1:0] seg_new;
    logic [BW-1:0]       bits;

    assign m    = mode_t'(mode);
    // armed keeps tick low through reset even when DIV=1 makes the match constant
    assign tick = en & armed & (div_cnt == DIV_LAST);
    assign busy = (conv_st == CONV_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (load)
                div_cnt <= '0;
            else if (en)
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_comb begin
        step_cl   = (step > limit) ? limit : step;
        sum       = {1'b0, count} + {1'b0, step};
        d         = (m == BOUNCE) ? dir : up;
        count_nxt = count;
        dir_nxt   = dir;
        done_nxt  = done;
        bnd_nxt   = 1'b0;
        if (load) begin
            count_nxt = (load_value > limit) ? limit : load_value;
            dir_nxt   = 1'b1;
            done_nxt  = 1'b0;
        end else if (tick && !done) begin
            if (d) begin
                if (count < limit) begin
                    count_nxt = (sum > {1'b0, limit}) ? limit : sum[WIDTH-1:0];
                end else begin
                    bnd_nxt = 1'b1;
                    case (m)
                        WRAP:    count_nxt = '0;
                        BOUNCE:  begin dir_nxt = 1'b0; count_nxt = limit - step_cl; end
                        ONESHOT: done_nxt = 1'b1;
                        default: ;
                    endcase
                end
            end else begin
                if (count != '0) begin
                    count_nxt = (count >= step) ? count - step : '0;
                end else begin
                    bnd_nxt = 1'b1;
                    case (m)
                        WRAP:    count_nxt = limit;
                        BOUNCE:  begin dir_nxt = 1'b1; count_nxt = step_cl; end
                        ONESHOT: done_nxt = 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            dir      <= 1'b1;
            done     <= 1'b0;
            boundary <= 1'b0;
        end else begin
            count    <= count_nxt;
            dir      <= dir_nxt;
            done     <= done_nxt;
            boundary <= bnd_nxt;
        end
    end

    always_comb begin
        adj = work;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
        shifted = {adj[4*DIGITS-2:0], bin[WIDTH-1]};
        seg_new = '1;
        for (int unsigned i = 0; i < DIGITS; i++)
            seg_new[7*i +: 7] = seg7(shifted[4*i +: 4]);
        chg   = (count_nxt != count);
        last  = (conv_st == CONV_RUN) && (bits == BW'(1));
        start = pend && ((conv_st == CONV_IDLE) || last);
    end

    // pend starts set so the count is converted once after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conv_st <= CONV_IDLE;
            pend    <= 1'b1;
            bin     <= '0;
            work    <= '0;
            bits    <= '0;
            bcd     <= '0;
            seg     <= {DIGITS{7'b1000000}};
        end else begin
            pend <= chg | (pend & ~start);
            case (conv_st)
                CONV_IDLE: begin
                    if (pend) begin
                        bin     <= count;
                        work    <= '0;
                        bits    <= BW'(WIDTH);
                        conv_st <= CONV_RUN;
                    end
                end
                CONV_RUN: begin
                    work <= shifted;
                    bin  <= bin << 1;
                    bits <= bits - 1'b1;
                    if (last) begin
                        bcd <= shifted;
                        seg <= seg_new;
                        if (pend) begin
                            bin  <= count;
                            work <= '0;
                            bits <= BW'(WIDTH);
                        end else begin
                            conv_st <= CONV_IDLE;
                        end
                    end
                end
                default: conv_st <= CONV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_counter_display.sv
// Directed bench for step_counter_display: DIV=4 instance for counting modes,
// DIV=1 instance for back-to-back conversion and async reset.
module tb_step_counter_display;

    localparam logic [20:0] SEG000 = {7'b1000000, 7'b1000000, 7'b1000000};
    localparam logic [20:0] SEG150 = {7'b1111001, 7'b0010010, 7'b1000000};
    localparam logic [20:0] SEG107 = {7'b1111001, 7'b1000000, 7'b1111000};
    localparam logic [20:0] SEG123 = {7'b1111001, 7'b0100100, 7'b0110000};
    localparam logic [20:0] SEG060 = {7'b1000000, 7'b0000010, 7'b1000000};

    logic        clk = 1'b0, reset = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  step = 8'd0, limit = 8'd150, load_value = 8'd0;
    logic        tick, boundary, busy, tick_b, boundary_b, busy_b;
    logic [7:0]  count, count_b;
    logic [11:0] bcd, bcd_b;
    logic [20:0] seg, seg_b;
    int          checks = 0, failures = 0;

    step_counter_display #(.WIDTH(8), .DIGITS(3), .DIV(4), .RST_LIMIT(150)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .mode(mode), .step(step),
        .limit(limit), .load(load), .load_value(load_value), .tick(tick),
        .count(count), .boundary(boundary), .busy(busy), .bcd(bcd), .seg(seg)
    );

    step_counter_display #(.WIDTH(8), .DIGITS(3), .DIV(1), .RST_LIMIT(150)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .mode(mode), .step(step),
        .limit(limit), .load(load), .load_value(load_value), .tick(tick_b),
        .count(count_b), .boundary(boundary_b), .busy(busy_b), .bcd(bcd_b), .seg(seg_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0: enc = 7'b1000000; 4'd1: enc = 7'b1111001; 4'd2: enc = 7'b0100100;
            4'd3: enc = 7'b0110000; 4'd4: enc = 7'b0011001; 4'd5: enc = 7'b0010010;
            4'd6: enc = 7'b0000010; 4'd7: enc = 7'b1111000; 4'd8: enc = 7'b0000000;
            4'd9: enc = 7'b0010000; default: enc = 7'b1111111;
        endcase
    endfunction

    task automatic do_load(input logic [7:0] v);
        load_value = v;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    // Wait (bounded) for the DIV=4 tick, then step past the edge that consumes it.
    task automatic do_tick;
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL tick_timeout got=0 exp=1"); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (tick !== 1'b0 || tick_b !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b/%b exp=0/0", tick, tick_b); end
        checks++; if (boundary !== 1'b0) begin failures++; $display("FAIL reset_boundary got=%b exp=0", boundary); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bcd !== 12'h000) begin failures++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
        checks++; if (seg !== SEG000) begin failures++; $display("FAIL reset_seg got=%b exp=%b", seg, SEG000); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_prescaler;
        mode = 2'd0; up = 1'b1; step = 8'd10; limit = 8'd150; en = 1'b1;
        do_load(8'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== (i == 3)) begin failures++; $display("FAIL prescale_tick%0d got=%b exp=%b", i, tick, (i == 3)); end
        end
        @(posedge clk); #1;
        en = 1'b0;
        begin
            bit seen = 1'b0;
            repeat (10) begin @(negedge clk); if (tick !== 1'b0) seen = 1'b1; end
            checks++; if (seen) begin failures++; $display("FAIL prescale_hold_tick got=1 exp=0"); end
        end
        checks++; if (count !== 8'd10) begin failures++; $display("FAIL prescale_hold_count got=%0d exp=10", count); end
    endtask

    task automatic test_wrap;
        mode = 2'd0; up = 1'b1; step = 8'd10; limit = 8'd150; en = 1'b1;
        do_load(8'd0);
        checks++; if (count !== 8'd0) begin failures++; $display("FAIL wrap_load got=%0d exp=0", count); end
        for (int k = 1; k <= 15; k++) begin
            logic [7:0] e;
            e = 8'(10 * k);
            do_tick();
            checks++;
            if (count !== e || boundary !== 1'b0) begin
                failures++; $display("FAIL wrap_step%0d got=%0d/%b exp=%0d/0", k, count, boundary, e);
            end
        end
        en = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        checks++; if (bcd !== 12'h150) begin failures++; $display("FAIL wrap_bcd150 got=%h exp=150", bcd); end
        checks++; if (seg !== SEG150) begin failures++; $display("FAIL wrap_seg150 got=%b exp=%b", seg, SEG150); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_idle got=%b exp=0", busy); end
        en = 1'b1;
        do_tick();
        checks++; if (count !== 8'd0 || boundary !== 1'b1) begin failures++; $display("FAIL wrap_roll got=%0d/%b exp=0/1", count, boundary); end
        @(posedge clk); #1;
        checks++; if (boundary !== 1'b0) begin failures++; $display("FAIL wrap_pulse got=%b exp=0", boundary); end
    endtask

    task automatic test_sat;
        logic [7:0] ec [6] = '{8'd40, 8'd80, 8'd120, 8'd150, 8'd150, 8'd150};
        logic       eb [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        mode = 2'd1; up = 1'b1; step = 8'd40; limit = 8'd150; en = 1'b1;
        do_load(8'd0);
        for (int k = 0; k < 6; k++) begin
            do_tick();
            checks++;
            if (count !== ec[k] || boundary !== eb[k]) begin
                failures++; $display("FAIL sat_step%0d got=%0d/%b exp=%0d/%b", k, count, boundary, ec[k], eb[k]);
            end
        end
        limit = 8'd100;
        do_tick();
        checks++; if (count !== 8'd150 || boundary !== 1'b1) begin failures++; $display("FAIL sat_lowered got=%0d/%b exp=150/1", count, boundary); end
        mode = 2'd0;
        do_tick();
        checks++; if (count !== 8'd0 || boundary !== 1'b1) begin failures++; $display("FAIL wrap_lowered got=%0d/%b exp=0/1", count, boundary); end
        limit = 8'd150;
    endtask

    task automatic test_bounce;
        logic [7:0] ec [7] = '{8'd60, 8'd120, 8'd150, 8'd90, 8'd30, 8'd0, 8'd60};
        logic       eb [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        mode = 2'd2; up = 1'b1; step = 8'd60; limit = 8'd150; en = 1'b1;
        do_load(8'd0);
        for (int k = 0; k < 7; k++) begin
            do_tick();
            checks++;
            if (count !== ec[k] || boundary !== eb[k]) begin
                failures++; $display("FAIL bounce_step%0d got=%0d/%b exp=%0d/%b", k, count, boundary, ec[k], eb[k]);
            end
        end
    endtask

    task automatic test_down_wrap;
        logic [7:0] ec [3] = '{8'd0, 8'd99, 8'd89};
        logic       eb [3] = '{1'b0, 1'b1, 1'b0};
        mode = 2'd0; up = 1'b0; step = 8'd10; limit = 8'd99; en = 1'b1;
        do_load(8'd5);
        checks++; if (count !== 8'd5) begin failures++; $display("FAIL down_load got=%0d exp=5", count); end
        for (int k = 0; k < 3; k++) begin
            do_tick();
            checks++;
            if (count !== ec[k] || boundary !== eb[k]) begin
                failures++; $display("FAIL down_step%0d got=%0d/%b exp=%0d/%b", k, count, boundary, ec[k], eb[k]);
            end
        end
        up = 1'b1;
    endtask

    task automatic test_step_zero;
        mode = 2'd0; up = 1'b1; step = 8'd0; limit = 8'd150; en = 1'b1;
        do_load(8'd200);
        checks++; if (count !== 8'd150) begin failures++; $display("FAIL load_clamp got=%0d exp=150", count); end
        do_tick();
        checks++; if (count !== 8'd0 || boundary !== 1'b1) begin failures++; $display("FAIL step0_bound got=%0d/%b exp=0/1", count, boundary); end
        do_tick();
        checks++; if (count !== 8'd0 || boundary !== 1'b0) begin failures++; $display("FAIL step0_hold got=%0d/%b exp=0/0", count, boundary); end
    endtask

    task automatic test_oneshot;
        logic [7:0] ec [6] = '{8'd100, 8'd200, 8'd255, 8'd255, 8'd255, 8'd255};
        logic       eb [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        mode = 2'd3; up = 1'b1; step = 8'd100; limit = 8'd255; en = 1'b1;
        do_load(8'd0);
        for (int k = 0; k < 6; k++) begin
            do_tick();
            checks++;
            if (count !== ec[k] || boundary !== eb[k]) begin
                failures++; $display("FAIL oneshot_step%0d got=%0d/%b exp=%0d/%b", k, count, boundary, ec[k], eb[k]);
            end
        end
        do_load(8'd7);
        checks++; if (count !== 8'd7) begin failures++; $display("FAIL oneshot_load got=%0d exp=7", count); end
        do_tick();
        checks++; if (count !== 8'd107 || boundary !== 1'b0) begin failures++; $display("FAIL oneshot_resume got=%0d/%b exp=107/0", count, boundary); end
        en = 1'b0;
    endtask

    task automatic test_latency;
        en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (seg !== SEG107 || bcd !== 12'h107) begin failures++; $display("FAIL lat_settled got=%h exp=107", bcd); end
        do_load(8'd123);
        checks++; if (count !== 8'd123 || busy !== 1'b0) begin failures++; $display("FAIL lat_load got=%0d/%b exp=123/0", count, busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lat_busy got=%b exp=1", busy); end
        repeat (7) @(posedge clk);
        #1;
        checks++; if (bcd !== 12'h107 || seg !== SEG107) begin failures++; $display("FAIL lat_early got=%h exp=107", bcd); end
        @(posedge clk); #1;
        checks++; if (bcd !== 12'h123 || seg !== SEG123) begin failures++; $display("FAIL lat_done got=%h exp=123", bcd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL lat_idle got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [20:0] es;
        mode = 2'd0; up = 1'b1; step = 8'd1; limit = 8'd255; en = 1'b1;
        do_load(8'd0);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c >= 12) begin
                es = {enc(bcd_b[11:8]), enc(bcd_b[7:4]), enc(bcd_b[3:0])};
                checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL b2b_busy%0d got=%b exp=1", c, busy_b); end
                checks++;
                if (seg_b !== es || bcd_b[11:8] > 4'd9 || bcd_b[7:4] > 4'd9 || bcd_b[3:0] > 4'd9) begin
                    failures++; $display("FAIL b2b_seg%0d got=%b exp=%b", c, seg_b, es);
                end
            end
        end
        en = 1'b0;
        checks++; if (count_b !== 8'd60) begin failures++; $display("FAIL b2b_count got=%0d exp=60", count_b); end
        repeat (18) @(posedge clk);
        #1;
        checks++; if (bcd_b !== 12'h060 || seg_b !== SEG060) begin failures++; $display("FAIL b2b_final got=%h exp=060", bcd_b); end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy_b); end
    endtask

    task automatic test_async_reset;
        en = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++; if (count !== 8'd0 || count_b !== 8'd0) begin failures++; $display("FAIL areset_count got=%0d/%0d exp=0/0", count, count_b); end
        checks++; if (busy !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b/%b exp=0/0", busy, busy_b); end
        checks++; if (seg !== SEG000 || seg_b !== SEG000) begin failures++; $display("FAIL areset_seg got=%b/%b exp=%b", seg, seg_b, SEG000); end
        checks++; if (bcd_b !== 12'h000 || tick_b !== 1'b0 || boundary_b !== 1'b0) begin failures++; $display("FAIL areset_misc got=%h/%b/%b exp=000/0/0", bcd_b, tick_b, boundary_b); end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_wrap();
        test_sat();
        test_bounce();
        test_down_wrap();
        test_step_zero();
        test_oneshot();
        test_latency();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
